// File: rtl/snake_pkg.sv
// Shared direction/state encodings for the snake body engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_RIGHT: opposite = DIR_LEFT;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_DOWN:  opposite = DIR_UP;
      default:   opposite = DIR_DOWN;
    endcase
  endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// Pending/committed direction registers; requests reversing the committed
// direction are dropped, the last accepted request before a commit wins.
module snake_dir_filter
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_init,
  input  logic       i_en,
  input  logic       i_dir_valid,
  input  logic [1:0] i_dir_req,
  input  logic       i_commit,
  output logic [1:0] o_pending,
  output logic [1:0] o_direction
);

  dir_t r_pending;
  dir_t r_direction;
  logic w_accept;

  assign w_accept = i_en && i_dir_valid && (dir_t'(i_dir_req) != opposite(r_direction));

  always_ff @(posedge clk) begin
    if (i_rst || i_init) begin
      r_pending   <= DIR_RIGHT;
      r_direction <= DIR_RIGHT;
    end else begin
      if (w_accept) r_pending <= dir_t'(i_dir_req);
      if (i_commit) r_direction <= r_pending;
    end
  end

  assign o_pending   = r_pending;
  assign o_direction = r_direction;

endmodule

// File: rtl/snake_body_engine.sv
// Snake body shift register with direction filter, growth on food and
// serial self-collision check (one segment compare per cycle).
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int X_MAX     = 160,
  parameter int Y_MAX     = 120,
  parameter int STEP      = 4,
  parameter int XW        = 8,
  parameter int YW        = 7,
  parameter int MAX_LEN   = 16,
  parameter int INIT_LEN  = 3,
  parameter int WRAP_MODE = 1
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           tick,
  input  logic                           dir_valid,
  input  logic [1:0]                     dir_req,
  input  logic [XW-1:0]                  food_x,
  input  logic [YW-1:0]                  food_y,
  input  logic [$clog2(MAX_LEN)-1:0]     rd_idx,
  output logic [XW-1:0]                  rd_x,
  output logic [YW-1:0]                  rd_y,
  output logic                           rd_live,
  output logic [XW-1:0]                  head_x,
  output logic [YW-1:0]                  head_y,
  output logic [1:0]                     direction,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic [1:0]                     state,
  output logic                           move_done,
  output logic                           ate,
  output logic                           dead
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [XW-1:0] XLAST = XW'(X_MAX - STEP);
  localparam logic [YW-1:0] YLAST = YW'(Y_MAX - STEP);
  localparam logic [XW-1:0] XSTEP = XW'(STEP);
  localparam logic [YW-1:0] YSTEP = YW'(STEP);
  localparam logic [YW-1:0] Y0    = YW'(((Y_MAX / 2) / STEP) * STEP);

  state_t          r_state;
  state_t          w_state_nx;
  logic [XW-1:0]   r_seg_x [MAX_LEN];
  logic [YW-1:0]   r_seg_y [MAX_LEN];
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_idx;
  logic [XW-1:0]   r_nx;
  logic [YW-1:0]   r_ny;
  logic            r_grow;
  logic            r_food_hit;
  logic            r_move_done;
  logic            r_ate;

  logic [1:0]      w_pending;
  logic [XW-1:0]   w_nx;
  logic [YW-1:0]   w_ny;
  logic            w_oob;
  logic            w_food;
  logic [LW-1:0]   w_lim;
  logic            w_hit;
  logic            w_last;
  logic            w_init;
  logic            w_launch;
  logic            w_commit_dir;
  logic            w_shift;

  snake_dir_filter u_dir (
    .clk         (CLOCK_50),
    .i_rst       (reset),
    .i_init      (w_init),
    .i_en        ((r_state == ST_RUN) || (r_state == ST_CHECK)),
    .i_dir_valid (dir_valid),
    .i_dir_req   (dir_req),
    .i_commit    (w_commit_dir),
    .o_pending   (w_pending),
    .o_direction (direction)
  );

  // Candidate head from the pending direction; w_oob flags an edge crossing
  // which is either wrapped or fatal depending on WRAP_MODE.
  always_comb begin
    w_nx  = r_seg_x[0];
    w_ny  = r_seg_y[0];
    w_oob = 1'b0;
    case (dir_t'(w_pending))
      DIR_RIGHT: if (r_seg_x[0] >= XLAST) begin w_nx = '0;    w_oob = 1'b1; end
                 else w_nx = r_seg_x[0] + XSTEP;
      DIR_LEFT:  if (r_seg_x[0] < XSTEP)  begin w_nx = XLAST; w_oob = 1'b1; end
                 else w_nx = r_seg_x[0] - XSTEP;
      DIR_DOWN:  if (r_seg_y[0] >= YLAST) begin w_ny = '0;    w_oob = 1'b1; end
                 else w_ny = r_seg_y[0] + YSTEP;
      default:   if (r_seg_y[0] < YSTEP)  begin w_ny = YLAST; w_oob = 1'b1; end
                 else w_ny = r_seg_y[0] - YSTEP;
    endcase
  end

  assign w_food = (w_nx == food_x) && (w_ny == food_y);
  assign w_lim  = r_grow ? r_len : r_len - LW'(1);
  assign w_hit  = (r_idx < w_lim) &&
                  (r_seg_x[r_idx[IW-1:0]] == r_nx) && (r_seg_y[r_idx[IW-1:0]] == r_ny);
  assign w_last = (r_idx + LW'(1)) >= w_lim;

  always_comb begin
    w_state_nx   = r_state;
    w_init       = 1'b0;
    w_launch     = 1'b0;
    w_commit_dir = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DEAD: begin
        if (start) begin
          w_init     = 1'b1;
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          w_commit_dir = 1'b1;
          if (w_oob && (WRAP_MODE == 0)) begin
            w_state_nx = ST_DEAD;
          end else begin
            w_launch   = 1'b1;
            w_state_nx = ST_CHECK;
          end
        end
      end
      default: begin
        if (w_hit) begin
          w_state_nx = ST_DEAD;
        end else if (w_last) begin
          w_shift    = 1'b1;
          w_state_nx = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Reset has priority over a commit landing on the same edge, so a move
  // interrupted in CHECK leaves no trace in the body or the pulses.
  always_ff @(posedge CLOCK_50) begin
    r_move_done <= 1'b0;
    r_ate       <= 1'b0;
    if (reset || w_init) begin
      r_len <= LW'(INIT_LEN);
      r_idx <= LW'(1);
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) r_seg_x[i] <= XW'((INIT_LEN - 1 - i) * STEP);
        else              r_seg_x[i] <= '0;
        r_seg_y[i] <= Y0;
      end
    end else if (w_launch) begin
      r_nx       <= w_nx;
      r_ny       <= w_ny;
      r_food_hit <= w_food;
      r_grow     <= w_food && (r_len < LW'(MAX_LEN));
      r_idx      <= LW'(1);
    end else if (w_shift) begin
      for (int unsigned i = 1; i < MAX_LEN; i++) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0]  <= r_nx;
      r_seg_y[0]  <= r_ny;
      r_len       <= r_len + LW'(r_grow);
      r_move_done <= 1'b1;
      r_ate       <= r_food_hit;
    end else if (r_state == ST_CHECK) begin
      r_idx <= r_idx + LW'(1);
    end
  end

  assign rd_x      = r_seg_x[rd_idx];
  assign rd_y      = r_seg_y[rd_idx];
  assign rd_live   = LW'(rd_idx) < r_len;
  assign head_x    = r_seg_x[0];
  assign head_y    = r_seg_y[0];
  assign length    = r_len;
  assign state     = r_state;
  assign move_done = r_move_done;
  assign ate       = r_ate;
  assign dead      = (r_state == ST_DEAD);

endmodule
